// File: rtl/arm_ctrl_pkg.sv
// Shared types and constants for the multicycle ARM-subset control unit.
// States, ALU op encodings, instruction opcodes and the memory-wait counter width.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        WB_R,
        MEM_ADDR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        BRANCH,
        ERROR
    } state_t;

    typedef logic [1:0] alu_op_t;

    localparam alu_op_t ALU_OP_ADD    = 2'b00;
    localparam alu_op_t ALU_OP_PASS_B = 2'b01;
    localparam alu_op_t ALU_OP_FUNCT  = 2'b10;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    // CBZ only fixes the top eight opcode bits; the rest belong to the immediate.
    localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;

    localparam int WAIT_W = 8;
    typedef logic [WAIT_W-1:0] wait_cnt_t;

    function automatic logic is_mem_wait_state(state_t s);
        return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control-unit <-> datapath/memory bundle: opcode and flags in, strobes and selects out.
// master = control unit, slave = datapath side.
interface multicycle_ctrl_if;
    import arm_ctrl_pkg::*;

    logic [10:0] op;
    logic        zero;
    logic        mem_ready;
    logic        mem_sel;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        reg_write;
    logic        mem_to_reg;
    logic        reg2loc;
    logic        alu_src;
    alu_op_t     alu_op;
    logic        error;
    logic [31:0] instr_count;

    modport master (
        input  op, zero, mem_ready,
        output mem_sel, mem_read, mem_write, ir_write, pc_write, pc_src,
               reg_write, mem_to_reg, reg2loc, alu_src, alu_op, error, instr_count
    );

    modport slave (
        output op, zero, mem_ready,
        input  mem_sel, mem_read, mem_write, ir_write, pc_write, pc_src,
               reg_write, mem_to_reg, reg2loc, alu_src, alu_op, error, instr_count
    );

endinterface

// File: rtl/multicycle_ctrl_opdecode.sv
// Opcode classifier: op[31:21] -> instruction class, anything unrecognised is illegal.
// Purely combinational, zero latency, no flow control.
module opdecode
    import arm_ctrl_pkg::*;
(
    input  logic [10:0] op,
    output logic        is_ldur,
    output logic        is_stur,
    output logic        is_cbz,
    output logic        is_rtype,
    output logic        illegal
);

    assign is_ldur  = (op == OP_LDUR);
    assign is_stur  = (op == OP_STUR);
    assign is_cbz   = (op[10:3] == OP_CBZ_PFX);
    assign is_rtype = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ORR);
    assign illegal  = !(is_ldur || is_stur || is_cbz || is_rtype);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for LDUR/STUR/CBZ/R-type; outputs decoded from state (R 4, LDUR 5, STUR 4, CBZ 3 cycles).
// Stalls in FETCH/MEM_RD/MEM_WR until mem_ready; waits of TIMEOUT_CYCLES lock into ERROR until reset.
module multicycle_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
)(
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.master  bus
);

    localparam logic [WAIT_W:0] TIMEOUT_LIM = (WAIT_W+1)'(TIMEOUT_CYCLES);

    state_t      state;
    wait_cnt_t   wait_cnt;
    logic        ldur_q;
    logic [31:0] instr_count_q;

    logic is_ldur, is_stur, is_cbz, is_rtype, illegal;

    opdecode u_opdecode (
        .op       (bus.op),
        .is_ldur  (is_ldur),
        .is_stur  (is_stur),
        .is_cbz   (is_cbz),
        .is_rtype (is_rtype),
        .illegal  (illegal)
    );

    logic waiting;
    logic wait_hit;
    logic timeout;

    assign waiting  = is_mem_wait_state(state);
    assign wait_hit = ({1'b0, wait_cnt} + {{WAIT_W{1'b0}}, 1'b1}) >= TIMEOUT_LIM;
    // A ready strobe in the last allowed cycle still completes the access.
    assign timeout  = waiting && !bus.mem_ready && wait_hit;

    logic    mem_sel_c, mem_read_c, mem_write_c, ir_write_c, pc_write_c, pc_src_c;
    logic    reg_write_c, mem_to_reg_c, reg2loc_c, alu_src_c, error_c;
    alu_op_t alu_op_c;

    always_comb begin
        mem_sel_c    = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        pc_src_c     = 1'b0;
        reg_write_c  = 1'b0;
        mem_to_reg_c = 1'b0;
        reg2loc_c    = 1'b0;
        alu_src_c    = 1'b0;
        alu_op_c     = ALU_OP_ADD;
        error_c      = 1'b0;
        case (state)
            FETCH: begin
                mem_read_c = 1'b1;
                ir_write_c = bus.mem_ready;
            end
            DECODE: begin
                reg2loc_c = is_stur || is_cbz;
            end
            EXEC_R: begin
                alu_op_c = ALU_OP_FUNCT;
            end
            WB_R: begin
                reg_write_c = 1'b1;
                pc_write_c  = 1'b1;
            end
            MEM_ADDR: begin
                alu_src_c = 1'b1;
            end
            MEM_RD: begin
                mem_sel_c  = 1'b1;
                mem_read_c = 1'b1;
            end
            MEM_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                pc_write_c   = 1'b1;
            end
            MEM_WR: begin
                mem_sel_c   = 1'b1;
                mem_write_c = 1'b1;
                reg2loc_c   = 1'b1;
                pc_write_c  = bus.mem_ready;
            end
            BRANCH: begin
                reg2loc_c  = 1'b1;
                alu_op_c   = ALU_OP_PASS_B;
                pc_write_c = 1'b1;
                pc_src_c   = bus.zero;
            end
            ERROR: begin
                error_c = 1'b1;
            end
            default: begin
                error_c = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= FETCH;
            wait_cnt      <= '0;
            ldur_q        <= 1'b0;
            instr_count_q <= '0;
        end else begin
            if (pc_write_c) begin
                instr_count_q <= instr_count_q + 32'd1;
            end
            // Leaving a wait state always needs ready (or a timeout), so clearing here doubles as clear-on-entry.
            if (waiting && !bus.mem_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            case (state)
                FETCH: begin
                    if (bus.mem_ready) begin
                        state <= DECODE;
                    end else if (timeout) begin
                        state <= ERROR;
                    end
                end
                DECODE: begin
                    ldur_q <= is_ldur;
                    if (is_ldur || is_stur) begin
                        state <= MEM_ADDR;
                    end else if (is_cbz) begin
                        state <= BRANCH;
                    end else if (is_rtype && !illegal) begin
                        state <= EXEC_R;
                    end else begin
                        state <= ERROR;
                    end
                end
                EXEC_R:   state <= WB_R;
                WB_R:     state <= FETCH;
                MEM_ADDR: state <= ldur_q ? MEM_RD : MEM_WR;
                MEM_RD: begin
                    if (bus.mem_ready) begin
                        state <= MEM_WB;
                    end else if (timeout) begin
                        state <= ERROR;
                    end
                end
                MEM_WB:   state <= FETCH;
                MEM_WR: begin
                    if (bus.mem_ready) begin
                        state <= FETCH;
                    end else if (timeout) begin
                        state <= ERROR;
                    end
                end
                BRANCH:   state <= FETCH;
                ERROR:    state <= ERROR;
                default:  state <= ERROR;
            endcase
        end
    end

    assign bus.mem_sel     = mem_sel_c;
    assign bus.mem_read    = mem_read_c;
    assign bus.mem_write   = mem_write_c;
    assign bus.ir_write    = ir_write_c;
    assign bus.pc_write    = pc_write_c;
    assign bus.pc_src      = pc_src_c;
    assign bus.reg_write   = reg_write_c;
    assign bus.mem_to_reg  = mem_to_reg_c;
    assign bus.reg2loc     = reg2loc_c;
    assign bus.alu_src     = alu_src_c;
    assign bus.alu_op      = alu_op_c;
    assign bus.error       = error_c;
    assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle expected strobe vectors go through a scoreboard queue.
// Output vector order: mem_sel mem_read mem_write ir_write pc_write pc_src reg_write mem_to_reg reg2loc alu_src alu_op[1:0] error
module tb_multicycle_ctrl;

    localparam logic [10:0] T_LDUR = 11'b11111000010;
    localparam logic [10:0] T_STUR = 11'b11111000000;
    localparam logic [10:0] T_ADD  = 11'b10001011000;
    localparam logic [10:0] T_SUB  = 11'b11001011000;
    localparam logic [10:0] T_AND  = 11'b10001010000;
    localparam logic [10:0] T_ORR  = 11'b10101010000;
    localparam logic [10:0] T_CBZ  = 11'b10110100101;
    localparam logic [10:0] T_BAD  = 11'h7FF;

    localparam logic [12:0] V_FETCH_W = 13'b0_1_0_0_0_0_0_0_0_0_00_0;
    localparam logic [12:0] V_FETCH_R = 13'b0_1_0_1_0_0_0_0_0_0_00_0;
    localparam logic [12:0] V_DEC     = 13'b0_0_0_0_0_0_0_0_0_0_00_0;
    localparam logic [12:0] V_DEC_R2L = 13'b0_0_0_0_0_0_0_0_1_0_00_0;
    localparam logic [12:0] V_EXEC    = 13'b0_0_0_0_0_0_0_0_0_0_10_0;
    localparam logic [12:0] V_WBR     = 13'b0_0_0_0_1_0_1_0_0_0_00_0;
    localparam logic [12:0] V_MADDR   = 13'b0_0_0_0_0_0_0_0_0_1_00_0;
    localparam logic [12:0] V_MRD     = 13'b1_1_0_0_0_0_0_0_0_0_00_0;
    localparam logic [12:0] V_MWB     = 13'b0_0_0_0_1_0_1_1_0_0_00_0;
    localparam logic [12:0] V_MWR_W   = 13'b1_0_1_0_0_0_0_0_1_0_00_0;
    localparam logic [12:0] V_MWR_R   = 13'b1_0_1_0_1_0_0_0_1_0_00_0;
    localparam logic [12:0] V_BR_Z1   = 13'b0_0_0_0_1_1_0_0_1_0_01_0;
    localparam logic [12:0] V_BR_Z0   = 13'b0_0_0_0_1_0_0_0_1_0_01_0;
    localparam logic [12:0] V_ERR     = 13'b0_0_0_0_0_0_0_0_0_0_00_1;

    logic clk = 1'b0;
    logic reset = 1'b0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.TIMEOUT_CYCLES(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [12:0] obs;
    assign obs = {bus.mem_sel, bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write,
                  bus.pc_src, bus.reg_write, bus.mem_to_reg, bus.reg2loc, bus.alu_src,
                  bus.alu_op, bus.error};

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_cnt = 32'd0;
    logic [12:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, record what the outputs must be, check them at the falling edge.
    task automatic cyc(input string tag, input logic [10:0] o, input logic z,
                       input logic rdy, input logic [12:0] e);
        logic [12:0] want;
        bus.op        = o;
        bus.zero      = z;
        bus.mem_ready = rdy;
        exp_q.push_back(e);
        if (e[8]) exp_cnt = exp_cnt + 32'd1;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk({tag, "_empty"}, 32'd1, 32'd0);
        end else begin
            want = exp_q.pop_front();
            chk(tag, {19'd0, obs}, {19'd0, want});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        bus.mem_ready = 1'b0;
        exp_cnt       = 32'd0;
        #2;
        chk("rst_vec", {19'd0, obs}, {19'd0, V_FETCH_W});
        chk("rst_cnt", bus.instr_count, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic do_rtype(input logic [10:0] o);
        cyc("r_fetch", o, 1'b0, 1'b1, V_FETCH_R);
        cyc("r_dec",   o, 1'b0, 1'b1, V_DEC);
        cyc("r_exec",  o, 1'b0, 1'b1, V_EXEC);
        cyc("r_wb",    o, 1'b0, 1'b1, V_WBR);
        chk("r_cnt", bus.instr_count, exp_cnt);
    endtask

    task automatic do_cbz(input logic z);
        cyc("cbz_fetch", T_CBZ, z, 1'b1, V_FETCH_R);
        cyc("cbz_dec",   T_CBZ, z, 1'b1, V_DEC_R2L);
        cyc("cbz_br",    T_CBZ, z, 1'b1, z ? V_BR_Z1 : V_BR_Z0);
        chk("cbz_cnt", bus.instr_count, exp_cnt);
    endtask

    logic [10:0] rops[4] = '{T_ADD, T_SUB, T_AND, T_ORR};

    initial begin
        bus.op        = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;

        do_reset();

        // LDUR with memory always ready
        cyc("ld_fetch", T_LDUR, 1'b0, 1'b1, V_FETCH_R);
        cyc("ld_dec",   T_LDUR, 1'b0, 1'b1, V_DEC);
        cyc("ld_addr",  T_LDUR, 1'b0, 1'b1, V_MADDR);
        cyc("ld_rd",    T_LDUR, 1'b0, 1'b1, V_MRD);
        cyc("ld_wb",    T_LDUR, 1'b0, 1'b1, V_MWB);
        chk("ld_cnt", bus.instr_count, 32'd1);

        do_cbz(1'b1);
        do_cbz(1'b0);
        chk("cbz_cnt2", bus.instr_count, 32'd3);

        foreach (rops[i]) do_rtype(rops[i]);

        // STUR: two fetch stalls, then three stalled cycles in MEM_WR
        cyc("st_fwait", T_STUR, 1'b0, 1'b0, V_FETCH_W);
        cyc("st_fwait", T_STUR, 1'b0, 1'b0, V_FETCH_W);
        cyc("st_fetch", T_STUR, 1'b0, 1'b1, V_FETCH_R);
        cyc("st_dec",   T_STUR, 1'b0, 1'b1, V_DEC_R2L);
        cyc("st_addr",  T_STUR, 1'b0, 1'b1, V_MADDR);
        for (int i = 0; i < 3; i++) cyc("st_wwait", T_STUR, 1'b0, 1'b0, V_MWR_W);
        cyc("st_wr",    T_STUR, 1'b0, 1'b1, V_MWR_R);
        chk("st_cnt", bus.instr_count, exp_cnt);

        // Illegal opcode locks into ERROR; ready pulses do nothing there
        cyc("bad_fetch", T_BAD, 1'b0, 1'b1, V_FETCH_R);
        cyc("bad_dec",   T_BAD, 1'b0, 1'b1, V_DEC);
        for (int i = 0; i < 3; i++) cyc("bad_err", T_BAD, 1'b0, i[0], V_ERR);
        chk("bad_cnt", bus.instr_count, exp_cnt);

        // Fetch timeout after 15 stalled cycles
        do_reset();
        for (int i = 0; i < 15; i++) cyc("to_wait", T_ADD, 1'b0, 1'b0, V_FETCH_W);
        cyc("to_err", T_ADD, 1'b0, 1'b0, V_ERR);
        for (int i = 0; i < 3; i++) cyc("to_ign", T_ADD, 1'b0, 1'b1, V_ERR);
        chk("to_cnt", bus.instr_count, 32'd0);

        // Ready on the last allowed cycle wins over the timeout
        do_reset();
        for (int i = 0; i < 14; i++) cyc("edge_wait", T_ADD, 1'b0, 1'b0, V_FETCH_W);
        cyc("edge_fetch", T_ADD, 1'b0, 1'b1, V_FETCH_R);
        cyc("edge_dec",   T_ADD, 1'b0, 1'b1, V_DEC);
        cyc("edge_exec",  T_ADD, 1'b0, 1'b1, V_EXEC);
        cyc("edge_wb",    T_ADD, 1'b0, 1'b1, V_WBR);
        chk("edge_cnt", bus.instr_count, 32'd1);

        // Reset in the middle of a stalled MEM_RD aborts the load
        cyc("ab_fetch", T_LDUR, 1'b0, 1'b1, V_FETCH_R);
        cyc("ab_dec",   T_LDUR, 1'b0, 1'b1, V_DEC);
        cyc("ab_addr",  T_LDUR, 1'b0, 1'b1, V_MADDR);
        cyc("ab_rd",    T_LDUR, 1'b0, 1'b0, V_MRD);
        #2;
        reset = 1'b0;
        #1;
        chk("ab_vec", {19'd0, obs}, {19'd0, V_FETCH_W});
        chk("ab_cnt", bus.instr_count, 32'd0);
        exp_cnt = 32'd0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        do_rtype(T_SUB);
        chk("post_cnt", bus.instr_count, 32'd1);

        chk("sb_drain", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
